// File: rtl/full_adder_pkg.sv
// full_adder_pkg: shared constants for the ripple-carry full adder.
package full_adder_pkg;
    localparam int MAX_WIDTH = 64;
endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: single-bit full adder, the leaf of the ripple chain.
module full_adder_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);
    assign s_o    = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
endmodule

// File: rtl/full_adder.sv
// full_adder: WIDTH-bit ripple-carry adder with a combinational result
// and a one-stage registered copy qualified by out_valid.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_q,
    output logic             out_valid
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_d;
    logic             carry_d;

    assign c[0]  = Cin;
    assign Carry = c[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a_i   (A[i]),
            .b_i   (B[i]),
            .cin_i (c[i]),
            .s_o   (Sum[i]),
            .cout_o(c[i+1])
        );
    end

    // Unqualified cycles keep the last captured result.
    always_comb begin
        sum_d   = in_valid ? Sum : sum_q;
        carry_d = in_valid ? Carry : carry_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= '0;
            carry_q   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            out_valid <= in_valid;
        end
    end
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: directed checks of WIDTH=1/4/8 full_adder instances.
module tb_full_adder;
    logic clk;
    logic rst_n;

    logic a1, b1, cin1, v1, s1, c1, sq1, cq1, ov1;
    logic [3:0] a4, b4, s4, sq4;
    logic cin4, v4, c4, cq4, ov4;
    logic [7:0] a8, b8, s8, sq8;
    logic cin8, v8, c8, cq8, ov8;

    int checks = 0;
    int errors = 0;

    full_adder #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Cin(cin1), .in_valid(v1),
        .Sum(s1), .Carry(c1), .sum_q(sq1), .carry_q(cq1), .out_valid(ov1)
    );
    full_adder #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .Cin(cin4), .in_valid(v4),
        .Sum(s4), .Carry(c4), .sum_q(sq4), .carry_q(cq4), .out_valid(ov4)
    );
    full_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .Cin(cin8), .in_valid(v8),
        .Sum(s8), .Carry(c8), .sum_q(sq8), .carry_q(cq8), .out_valid(ov8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_s [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic exp_c [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [8:0] ref9;
        logic [7:0] ms;
        logic mc, mv;
        rst_n = 1'b0;
        {a1, b1, cin1, v1} = '0;
        {a4, b4, cin4, v4} = '0;
        {a8, b8, cin8, v8} = '0;
        #1;
        check("rst_sum_q", sq1, 0);
        check("rst_carry_q", cq1, 0);
        check("rst_out_valid", ov1, 0);
        for (int i = 0; i < 8; i++) begin
            {a1, b1, cin1} = 3'(i);
            #1;
            check($sformatf("tt%0d_sum", i), s1, exp_s[i]);
            check($sformatf("tt%0d_carry", i), c1, exp_c[i]);
            #99;
        end

        @(negedge clk);
        rst_n = 1'b1;
        {a1, b1, cin1, v1} = 4'b1101;
        #1;
        check("pre_edge_sum_q", sq1, 0);
        check("pre_edge_carry_q", cq1, 0);
        check("pre_edge_out_valid", ov1, 0);
        @(posedge clk) #1;
        check("cap_sum_q", sq1, 0);
        check("cap_carry_q", cq1, 1);
        check("cap_out_valid", ov1, 1);

        @(negedge clk);
        {a1, b1, cin1, v1} = 4'b1001;
        @(posedge clk) #1;
        check("hold_cap_sum_q", sq1, 1);
        check("hold_cap_carry_q", cq1, 0);
        @(negedge clk);
        v1 = 1'b0;
        a1 = 1'b0;
        #1;
        check("hold_comb_sum", s1, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk) #1;
            check($sformatf("hold%0d_sum_q", i), sq1, 1);
            check($sformatf("hold%0d_out_valid", i), ov1, 0);
        end

        @(negedge clk);
        {a1, b1, cin1, v1} = 4'b1111;
        @(posedge clk) #1;
        check("pre_rst_out_valid", ov1, 1);
        check("pre_rst_carry_q", cq1, 1);
        check("pre_rst_sum_q", sq1, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_sum_q", sq1, 0);
        check("arst_carry_q", cq1, 0);
        check("arst_out_valid", ov1, 0);
        check("arst_sum", s1, 1);
        check("arst_carry", c1, 1);
        @(posedge clk) #1;
        check("arst_edge_out_valid", ov1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        {a1, b1, cin1, v1} = 4'b1011;
        @(posedge clk) #1;
        check("post_rst_sum_q", sq1, 0);
        check("post_rst_carry_q", cq1, 1);
        check("post_rst_out_valid", ov1, 1);

        @(negedge clk);
        {a4, b4, cin4, v4} = {4'hF, 4'hF, 1'b1, 1'b1};
        #1;
        check("w4_ff1_sum", s4, 4'hF);
        check("w4_ff1_carry", c4, 1);
        @(posedge clk) #1;
        check("w4_ff1_sum_q", sq4, 4'hF);
        check("w4_ff1_carry_q", cq4, 1);
        check("w4_ff1_out_valid", ov4, 1);
        {a4, b4, cin4, v4} = {4'hF, 4'h0, 1'b1, 1'b0};
        #1;
        check("w4_f01_sum", s4, 4'h0);
        check("w4_f01_carry", c4, 1);
        {a4, b4, cin4} = {4'h5, 4'hA, 1'b0};
        #1;
        check("w4_5a0_sum", s4, 4'hF);
        check("w4_5a0_carry", c4, 0);

        ms = '0;
        mc = 1'b0;
        mv = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            cin8 = 1'($urandom);
            v8 = 1'($urandom);
            #1;
            ref9 = {1'b0, a8} + {1'b0, b8} + {8'b0, cin8};
            check("w8_comb", {c8, s8}, ref9);
            if (v8) begin
                ms = ref9[7:0];
                mc = ref9[8];
            end
            mv = v8;
            @(posedge clk) #1;
            check("w8_sum_q", sq8, ms);
            check("w8_carry_q", cq8, mc);
            check("w8_out_valid", ov8, mv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
